// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter for the single register-file write port,
//               with a pending-write scoreboard and an optional same-cycle
//               write-to-read bypass, enabled by defining RF_WR_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    input  logic                      claimValid,
    input  logic [ADDR_W-1:0]         claimAddr,
    output logic                      writeEnable,
    output logic [ADDR_W-1:0]         writeAddr,
    output logic [DATA_W-1:0]         writeData,
    output logic [NUM_REGS-1:0]       busyMask,
    input  logic [ADDR_W-1:0]         rdAddr1,
    input  logic [ADDR_W-1:0]         rdAddr2,
    input  logic [DATA_W-1:0]         rfData1,
    input  logic [DATA_W-1:0]         rfData2,
    output logic [DATA_W-1:0]         rdData1,
    output logic [DATA_W-1:0]         rdData2
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_PTR_W-1:0]  r_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_REGS-1:0] r_busy;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_any;
    logic [c_PTR_W-1:0]  w_gidx;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_accept;
    int                  w_idx;

    // Search starts at the pointer and wraps; first valid requester wins.
    always_comb begin
        w_grant    = '0;
        w_any      = 1'b0;
        w_gidx     = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any && reqValid[w_idx]) begin
                w_any          = 1'b1;
                w_grant[w_idx] = 1'b1;
                w_gidx         = c_PTR_W'(w_idx);
                w_sel_addr     = reqAddr[w_idx*ADDR_W +: ADDR_W];
                w_sel_data     = reqData[w_idx*DATA_W +: DATA_W];
            end
        end
    end

    assign reqReady = rst ? '0 : w_grant;
    assign w_accept = |(reqValid & reqReady);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
                r_ptr   <= (w_gidx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    // Claim is applied after the clear so a same-edge claim keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (claimValid && (claimAddr == ADDR_W'(r))) begin
                    r_busy[r] <= 1'b1;
                end else if (r_we && (r_waddr == ADDR_W'(r))) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    assign writeEnable = r_we;
    assign writeAddr   = r_waddr;
    assign writeData   = r_wdata;
    assign busyMask    = r_busy;

`ifdef RF_WR_BYPASS_EN
    assign rdData1 = (r_we && (r_waddr == rdAddr1)) ? r_wdata : rfData1;
    assign rdData2 = (r_we && (r_waddr == rdAddr2)) ? r_wdata : rfData2;
`else
    // Read addresses only matter to the register file itself in this build.
    logic w_unused_rdaddr;
    assign w_unused_rdaddr = ^{rdAddr1, rdAddr2};
    assign rdData1 = rfData1;
    assign rdData2 = rfData2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        reqValid;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr;
    logic [NUM_REQ*DATA_W-1:0] reqData;
    logic [NUM_REQ-1:0]        reqReady;
    logic                      claimValid;
    logic [ADDR_W-1:0]         claimAddr;
    logic                      writeEnable;
    logic [ADDR_W-1:0]         writeAddr;
    logic [DATA_W-1:0]         writeData;
    logic [NUM_REGS-1:0]       busyMask;
    logic [ADDR_W-1:0]         rdAddr1;
    logic [ADDR_W-1:0]         rdAddr2;
    logic [DATA_W-1:0]         rfData1;
    logic [DATA_W-1:0]         rfData2;
    logic [DATA_W-1:0]         rdData1;
    logic [DATA_W-1:0]         rdData2;

    int checks = 0;
    int errors = 0;

    rf_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .reqAddr    (reqAddr),
        .reqData    (reqData),
        .reqReady   (reqReady),
        .claimValid (claimValid),
        .claimAddr  (claimAddr),
        .writeEnable(writeEnable),
        .writeAddr  (writeAddr),
        .writeData  (writeData),
        .busyMask   (busyMask),
        .rdAddr1    (rdAddr1),
        .rdAddr2    (rdAddr2),
        .rfData1    (rfData1),
        .rfData2    (rfData2),
        .rdData1    (rdData1),
        .rdData2    (rdData2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; reqValid = 3'b111; claimValid = 1'b0; claimAddr = '0;
        reqAddr = '0; reqData = '0;
        rdAddr1 = '0; rdAddr2 = '0; rfData1 = '0; rfData2 = '0;
        #1;
        checks++;
        if (reqReady !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b expected 000", reqReady);
        end
        tick(); tick();
        checks++;
        if (writeEnable !== 1'b0 || writeAddr !== '0 || writeData !== '0 || busyMask !== '0) begin
            errors++; $display("FAIL reset_regs: we=%b addr=%0d data=%h busy=%b expected 0", writeEnable, writeAddr, writeData, busyMask);
        end
        reqValid = '0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (writeEnable !== 1'b0 || busyMask !== '0 || reqReady !== 3'b000) begin
                errors++; $display("FAIL idle_cycle%0d: we=%b busy=%b ready=%b expected 0/0/000", i, writeEnable, busyMask, reqReady);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int exp_g[4] = '{0, 1, 2, 0};
        reqValid = 3'b111;
        reqAddr  = {3'd3, 3'd2, 3'd1};
        reqData  = {32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (reqReady !== 3'(1 << exp_g[i])) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, reqReady, 3'(1 << exp_g[i]));
            end
            tick();
            checks++;
            if (writeEnable !== 1'b1 || writeAddr !== 3'(exp_g[i] + 1) || writeData !== 32'(32'hA + exp_g[i])) begin
                errors++; $display("FAIL rr_write%0d: we=%b addr=%0d data=%h expected 1/%0d/%h", i, writeEnable, writeAddr, writeData, exp_g[i] + 1, 32'hA + exp_g[i]);
            end
        end
        reqValid = '0;
        #1;
        checks++;
        if (reqReady !== 3'b000) begin
            errors++; $display("FAIL rr_idle_ready: got %b expected 000", reqReady);
        end
        tick();
        checks++;
        if (writeEnable !== 1'b0) begin
            errors++; $display("FAIL rr_we_drop: got %b expected 0", writeEnable);
        end
    endtask

    task automatic test_scoreboard();
        claimValid = 1'b1; claimAddr = 3'd5;
        tick();
        claimValid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                reqValid = 3'b010; reqAddr = {3'd0, 3'd5, 3'd0}; reqData = {32'h0, 32'h55, 32'h0};
                #1;
                checks++;
                if (reqReady !== 3'b010) begin
                    errors++; $display("FAIL sb_grant: got %b expected 010", reqReady);
                end
            end
            checks++;
            if (busyMask !== 8'h20) begin
                errors++; $display("FAIL sb_busy_c%0d: got %b expected 00100000", c, busyMask);
            end
            tick();
        end
        reqValid = '0;
        checks++;
        if (writeEnable !== 1'b1 || writeAddr !== 3'd5 || writeData !== 32'h55 || busyMask !== 8'h20) begin
            errors++; $display("FAIL sb_write: we=%b addr=%0d data=%h busy=%b expected 1/5/55/00100000", writeEnable, writeAddr, writeData, busyMask);
        end
        tick();
        checks++;
        if (writeEnable !== 1'b0 || busyMask !== 8'h00) begin
            errors++; $display("FAIL sb_clear: we=%b busy=%b expected 0/00000000", writeEnable, busyMask);
        end
    endtask

    task automatic test_claim_wins();
        claimValid = 1'b1; claimAddr = 3'd2;
        reqValid = 3'b001; reqAddr = {3'd0, 3'd0, 3'd2}; reqData = {32'h0, 32'h0, 32'h22};
        tick();
        reqValid = '0;
        checks++;
        if (writeEnable !== 1'b1 || writeAddr !== 3'd2 || busyMask !== 8'h04) begin
            errors++; $display("FAIL cw_setup: we=%b addr=%0d busy=%b expected 1/2/00000100", writeEnable, writeAddr, busyMask);
        end
        tick();
        claimValid = 1'b0;
        checks++;
        if (busyMask !== 8'h04 || writeEnable !== 1'b0) begin
            errors++; $display("FAIL cw_claim_wins: busy=%b we=%b expected 00000100/0", busyMask, writeEnable);
        end
        reqValid = 3'b001;
        tick();
        reqValid = '0;
        tick();
        checks++;
        if (busyMask !== 8'h00) begin
            errors++; $display("FAIL cw_clear: busy=%b expected 00000000", busyMask);
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] exp1;
        reqValid = 3'b100; reqAddr = {3'd4, 3'd0, 3'd0}; reqData = {32'hDEAD, 32'h0, 32'h0};
        tick();
        reqValid = '0;
        rdAddr1 = 3'd4; rfData1 = 32'h1234;
        rdAddr2 = 3'd3; rfData2 = 32'h5678;
`ifdef RF_WR_BYPASS_EN
        exp1 = 32'hDEAD;
`else
        exp1 = 32'h1234;
`endif
        #1;
        checks++;
        if (writeEnable !== 1'b1 || writeAddr !== 3'd4 || rdData1 !== exp1 || rdData2 !== 32'h5678) begin
            errors++; $display("FAIL bypass_hit: we=%b addr=%0d rd1=%h rd2=%h expected 1/4/%h/5678", writeEnable, writeAddr, rdData1, rdData2, exp1);
        end
        tick();
        checks++;
        if (rdData1 !== 32'h1234) begin
            errors++; $display("FAIL bypass_idle: rd1=%h expected 1234", rdData1);
        end
    endtask

    task automatic test_reset_mid();
        reqValid = 3'b001; reqAddr = '0; reqData = '0;
        tick();
        reqValid = 3'b010; reqAddr = {3'd0, 3'd6, 3'd0}; reqData = {32'h0, 32'h66, 32'h0};
        claimValid = 1'b1; claimAddr = 3'd6;
        #1;
        checks++;
        if (reqReady !== 3'b010) begin
            errors++; $display("FAIL rm_grant: got %b expected 010", reqReady);
        end
        tick();
        claimValid = 1'b0;
        reqValid = 3'b111;
        rst = 1'b1;
        #1;
        checks++;
        if (writeEnable !== 1'b0 || busyMask !== 8'h00 || reqReady !== 3'b000) begin
            errors++; $display("FAIL rm_in_reset: we=%b busy=%b ready=%b expected 0/00000000/000", writeEnable, busyMask, reqReady);
        end
        tick();
        checks++;
        if (writeEnable !== 1'b0) begin
            errors++; $display("FAIL rm_no_commit: we=%b expected 0", writeEnable);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (reqReady !== 3'b001) begin
            errors++; $display("FAIL rm_ptr_zero: got %b expected 001", reqReady);
        end
        tick();
        reqValid = '0;
        checks++;
        if (writeEnable !== 1'b1 || writeAddr !== 3'd0) begin
            errors++; $display("FAIL rm_post_write: we=%b addr=%0d expected 1/0", writeEnable, writeAddr);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_scoreboard();
        test_claim_wins();
        test_bypass();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
